// File: rtl/prio_q_heap_seq.sv
// prio_q_heap_seq: binary-heap priority queue with valid/ready command port and multi-cycle sift FSM
module prio_q_heap_seq #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 31,
  parameter int CNT_W    = $clog2(DEPTH+1),
  parameter bit MAX_HEAP = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_op_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [DATA_W-1:0] heap_root_o,
  output logic              root_valid_o,
  output logic [CNT_W-1:0]  heap_count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d, p, c, wa, wb;
  logic [CNT_W:0] l, r;
  logic [DATA_W-1:0] mem_q [0:DEPTH];
  logic [DATA_W-1:0] out_data_q, out_data_d, key_i, key_p, key_l, key_r, key_c, da, db;
  logic out_valid_q, out_valid_d, err_q, err_d, full, empty, lv, rv, pick_r, we_a, we_b;
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return MAX_HEAP ? a > b : a < b;
  endfunction
  assign p      = idx_q >> 1;
  // child indices carry one extra bit so 2*idx never wraps past DEPTH
  assign l      = {idx_q, 1'b0};
  assign r      = {idx_q, 1'b1};
  assign lv     = l <= {1'b0, cnt_q};
  assign rv     = r <= {1'b0, cnt_q};
  assign key_i  = mem_q[idx_q];
  assign key_p  = mem_q[p];
  assign key_l  = mem_q[l[CNT_W-1:0]];
  assign key_r  = mem_q[r[CNT_W-1:0]];
  assign pick_r = rv && better(key_r, key_l);
  assign c      = pick_r ? r[CNT_W-1:0] : l[CNT_W-1:0];
  assign key_c  = pick_r ? key_r : key_l;
  assign full   = cnt_q == CNT_W'(DEPTH);
  assign empty  = cnt_q == '0;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    we_a        = 1'b0;
    we_b        = 1'b0;
    wa          = idx_q;
    da          = key_p;
    wb          = p;
    db          = key_i;
    case (state_q)
      IDLE: if (in_valid_i) begin
        if (in_op_i ? full : empty) err_d = 1'b1;
        else if (in_op_i) begin
          we_a    = 1'b1;
          wa      = cnt_q + CNT_W'(1);
          da      = in_data_i;
          cnt_d   = cnt_q + CNT_W'(1);
          idx_d   = cnt_q + CNT_W'(1);
          state_d = SIFT_UP;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[1];
          we_a        = 1'b1;
          wa          = CNT_W'(1);
          da          = mem_q[cnt_q];
          cnt_d       = cnt_q - CNT_W'(1);
          idx_d       = CNT_W'(1);
          state_d     = cnt_q > CNT_W'(2) ? SIFT_DOWN : IDLE;
        end
      end
      SIFT_UP: if (idx_q == CNT_W'(1) || !better(key_i, key_p)) state_d = IDLE;
      else begin
        we_a  = 1'b1;
        we_b  = 1'b1;
        idx_d = p;
      end
      SIFT_DOWN: if (!lv || !better(key_c, key_i)) state_d = IDLE;
      else begin
        we_a  = 1'b1;
        da    = key_c;
        we_b  = 1'b1;
        wb    = c;
        idx_d = c;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_n_i && we_a) mem_q[wa] <= da;
    if (rst_n_i && we_b) mem_q[wb] <= db;
  end
  assign in_ready_o   = state_q == IDLE;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign heap_root_o  = mem_q[1];
  assign root_valid_o = !empty && state_q == IDLE;
  assign heap_count_o = cnt_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign err_o        = err_q;
endmodule

// File: tb/tb_prio_q_heap_seq.sv
// tb_prio_q_heap_seq: min- and max-heap instances driven in lockstep and checked against sorted-queue models
module tb_prio_q_heap_seq;
  localparam int DW = 32, DEPTH = 31, CW = 5;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_op = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic rdy [2], ov [2], rv [2], full [2], empty [2], err [2];
  logic [DW-1:0] od [2], root [2];
  logic [CW-1:0] cnt [2];
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mq0 [$], mq1 [$];
  logic [DW-1:0] lastpop [2];
  int mcnt;
  typedef struct { bit op; logic [DW-1:0] d, emin, emax; } vec_t;
  vec_t tv [16];
  always #5 clk = ~clk;
  prio_q_heap_seq #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_HEAP(1'b0)) u_min (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]), .in_op_i(in_op),
    .in_data_i(in_data), .out_valid_o(ov[0]), .out_data_o(od[0]), .heap_root_o(root[0]),
    .root_valid_o(rv[0]), .heap_count_o(cnt[0]), .full_o(full[0]), .empty_o(empty[0]), .err_o(err[0]));
  prio_q_heap_seq #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_HEAP(1'b1)) u_max (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]), .in_op_i(in_op),
    .in_data_i(in_data), .out_valid_o(ov[1]), .out_data_o(od[1]), .heap_root_o(root[1]),
    .root_valid_o(rv[1]), .heap_count_o(cnt[1]), .full_o(full[1]), .empty_o(empty[1]), .err_o(err[1]));
  task automatic chk(input string name, input int h, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, h, act, exp);
    end
  endtask
  task automatic check_state;
    for (int h = 0; h < 2; h++) begin
      chk("count", h, cnt[h], mcnt);
      chk("full", h, full[h], mcnt == DEPTH);
      chk("empty", h, empty[h], mcnt == 0);
      chk("root_valid", h, rv[h], mcnt > 0 && rdy[h]);
      chk("out_data_hold", h, od[h], lastpop[h]);
      if (mcnt > 0) chk("root", h, root[h], h == 0 ? mq0[0] : mq1[$]);
    end
  endtask
  task automatic wait_idle(output int w);
    w = 0;
    while (!(rdy[0] && rdy[1]) && w < 50) begin @(posedge clk); #1; w++; end
  endtask
  task automatic model_reset;
    mq0.delete();
    mq1.delete();
    mcnt = 0;
    lastpop[0] = '0;
    lastpop[1] = '0;
  endtask
  task automatic cmd(input bit op, input logic [DW-1:0] d);
    int w, n;
    int b [2];
    bit e;
    wait_idle(w);
    chk("ready_wait", 0, w < 50, 1);
    n = mcnt;
    e = op ? n == DEPTH : n == 0;
    if (!e && op) begin
      mq0.push_back(d); mq0.sort();
      mq1.push_back(d); mq1.sort();
      mcnt++;
    end else if (!e) begin
      lastpop[0] = mq0.pop_front();
      lastpop[1] = mq1.pop_back();
      mcnt--;
    end
    in_valid = 1'b1; in_op = op; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int h = 0; h < 2; h++) begin
      chk("out_valid", h, ov[h], !op && !e);
      chk("err", h, err[h], e);
      chk("ready_after", h, rdy[h], e || (!op && n <= 2));
      chk("out_data", h, od[h], lastpop[h]);
    end
    b[0] = 0; b[1] = 0;
    while (!(rdy[0] && rdy[1]) && b[0] + b[1] < 60) begin
      for (int h = 0; h < 2; h++) if (!rdy[h]) b[h]++;
      @(posedge clk); #1;
    end
    if (op && !e) for (int h = 0; h < 2; h++) chk("ins_latency", h, b[h] <= $clog2(n + 2), 1);
    check_state;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    int w;
    tv[0]  = '{1, 5, 5, 5};  tv[1]  = '{1, 3, 3, 5};  tv[2]  = '{1, 8, 3, 8};  tv[3]  = '{1, 1, 1, 8};
    tv[4]  = '{0, 0, 1, 8};  tv[5]  = '{0, 0, 3, 5};  tv[6]  = '{0, 0, 5, 3};  tv[7]  = '{0, 0, 8, 1};
    tv[8]  = '{1, 7, 7, 7};  tv[9]  = '{1, 7, 7, 7};  tv[10] = '{1, 2, 2, 7};  tv[11] = '{1, 9, 2, 9};
    tv[12] = '{0, 0, 2, 9};  tv[13] = '{0, 0, 7, 7};  tv[14] = '{0, 0, 7, 7};  tv[15] = '{0, 0, 9, 2};
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int h = 0; h < 2; h++) begin
      chk("rst_ready", h, rdy[h], 1);
      chk("rst_out_valid", h, ov[h], 0);
      chk("rst_err", h, err[h], 0);
    end
    check_state();
    for (int i = 0; i < 16; i++) begin
      cmd(tv[i].op, tv[i].d);
      chk(tv[i].op ? "tbl_root" : "tbl_pop", 0, tv[i].op ? root[0] : od[0], tv[i].emin);
      chk(tv[i].op ? "tbl_root" : "tbl_pop", 1, tv[i].op ? root[1] : od[1], tv[i].emax);
    end
    chk("t2_empty", 0, empty[0], 1);
    for (int k = 31; k >= 1; k--) cmd(1'b1, DW'(k));
    chk("t3_full", 0, full[0], 1);
    cmd(1'b1, 32'd100);
    chk("t3_count", 0, cnt[0], 31);
    chk("t3_root_min", 0, root[0], 1);
    chk("t3_root_max", 1, root[1], 31);
    repeat (31) cmd(1'b0, '0);
    cmd(1'b0, '0);
    chk("t4_count", 0, cnt[0], 0);
    repeat (400) begin
      logic [DW-1:0] d;
      d = $urandom_range(0, 3) == 0 ? DW'($urandom) : DW'($urandom_range(0, 20));
      cmd($urandom_range(0, 99) < (mcnt < 16 ? 65 : 40), d);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_state();
    for (int k = 0; k < 10; k++) cmd(1'b1, DW'($urandom_range(0, 50)));
    wait_idle(w);
    in_valid = 1'b1; in_op = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int h = 0; h < 2; h++) chk("t6_busy", h, rdy[h], 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int h = 0; h < 2; h++) begin
      chk("t6_count", h, cnt[h], 0);
      chk("t6_ready", h, rdy[h], 1);
      chk("t6_out_valid", h, ov[h], 0);
      chk("t6_err", h, err[h], 0);
    end
    check_state();
    cmd(1'b1, 32'd4);
    cmd(1'b1, 32'd2);
    cmd(1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
